// File: rtl/fir_coef_ctrl_if.sv
// Host coefficient stream for fir_coef_ctrl.
// The host is the master; the controller is the slave.
interface fir_coef_ctrl_if;
   logic [15:0] coef_in;
   logic        coef_valid;
   logic        coef_ready;

   modport master (
      output coef_in,
      output coef_valid,
      input  coef_ready
   );

   modport slave (
      input  coef_in,
      input  coef_valid,
      output coef_ready
   );
endinterface

// File: rtl/fir_coef_ctrl.sv
// Coefficient load / optional readback-verify sequencer for FIR_core.
// Streams host words into the core memory, then enables filtering.
module fir_coef_ctrl #(
   parameter int NUM_COF = 64,
   parameter int AW      = 6
) (
   input  logic           clk2,
   input  logic           rstn,
   input  logic           start,
   input  logic           verify_en,
   fir_coef_ctrl_if.slave host,
   input  logic [15:0]    rd_data,
   output logic [15:0]    cin,
   output logic [AW-1:0]  caddr,
   output logic [2:0]     cload,
   output logic           valid_in,
   output logic           busy,
   output logic           done,
   output logic           err
);

   localparam logic [AW-1:0] LAST = AW'(NUM_COF - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_WAIT, S_WR_SETUP, S_WR_STB,
      S_RD_SETUP, S_RD_STB, S_RD_CAP, S_CHECK,
      S_RUN, S_ERR
   } state_e;

   state_e        state_q, state_d;
   logic [15:0]   cin_q, cin_d;
   logic [15:0]   wsum_q, wsum_d;
   logic [15:0]   rsum_q, rsum_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          ver_q, ver_d;
   logic          valid_q, done_q;
   logic          take, hs, last;

   assign take = start &&
                 (state_q inside {S_IDLE, S_RUN, S_ERR});
   assign hs   = (state_q == S_WR_WAIT) && host.coef_valid;
   assign last = (addr_q == LAST);

   always_ff @(posedge clk2 or negedge rstn) begin
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (start) state_d = S_WR_WAIT;
         S_WR_WAIT:  if (host.coef_valid) state_d = S_WR_SETUP;
         S_WR_SETUP: state_d = S_WR_STB;
         S_WR_STB: begin
            if (!last)      state_d = S_WR_WAIT;
            else if (ver_q) state_d = S_RD_SETUP;
            else            state_d = S_RUN;
         end
         S_RD_SETUP: state_d = S_RD_STB;
         S_RD_STB:   state_d = S_RD_CAP;
         S_RD_CAP:   state_d = last ? S_CHECK : S_RD_SETUP;
         S_CHECK:    state_d = (wsum_q == rsum_q) ? S_RUN : S_ERR;
         S_RUN:      if (start) state_d = S_WR_WAIT;
         S_ERR:      if (start) state_d = S_WR_WAIT;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      host.coef_ready = 1'b0;
      cload           = 3'b110;
      busy            = 1'b1;
      err             = 1'b0;
      unique case (state_q)
         S_IDLE, S_RUN: busy = 1'b0;
         S_ERR: begin
            busy = 1'b0;
            err  = 1'b1;
         end
         S_WR_WAIT:            host.coef_ready = 1'b1;
         S_WR_SETUP:           cload = 3'b010;
         S_WR_STB:             cload = 3'b000;
         S_RD_SETUP, S_RD_CAP: cload = 3'b011;
         S_RD_STB:             cload = 3'b001;
         default:              cload = 3'b110;
      endcase
   end

   // Address holds at LAST; it only reloads when the read pass begins.
   always_comb begin
      cin_d  = cin_q;
      wsum_d = wsum_q;
      rsum_d = rsum_q;
      addr_d = addr_q;
      ver_d  = ver_q;
      if (take) begin
         addr_d = '0;
         wsum_d = '0;
         rsum_d = '0;
         ver_d  = verify_en;
      end
      if (hs) begin
         cin_d  = host.coef_in;
         wsum_d = wsum_q + host.coef_in;
      end
      if (state_q == S_WR_STB) begin
         if (!last)      addr_d = addr_q + 1'b1;
         else if (ver_q) addr_d = '0;
      end
      if (state_q == S_RD_CAP) begin
         rsum_d = rsum_q + rd_data;
         if (!last) addr_d = addr_q + 1'b1;
      end
   end

   always_ff @(posedge clk2 or negedge rstn) begin
      if (!rstn) begin
         cin_q   <= '0;
         wsum_q  <= '0;
         rsum_q  <= '0;
         addr_q  <= '0;
         ver_q   <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         cin_q   <= cin_d;
         wsum_q  <= wsum_d;
         rsum_q  <= rsum_d;
         addr_q  <= addr_d;
         ver_q   <= ver_d;
         valid_q <= (state_d == S_RUN);
         done_q  <= (state_d == S_RUN) && (state_q != S_RUN);
      end
   end

   assign cin      = cin_q;
   assign caddr    = addr_q;
   assign valid_in = valid_q;
   assign done     = done_q;

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Self-checking bench for fir_coef_ctrl with a behavioural core model.
// Sessions are checked against word lists, sums and cycle counts.
module tb_fir_coef_ctrl;
   localparam int N = 64;

   logic        clk2 = 1'b0;
   logic        rstn = 1'b1;
   logic        start = 1'b0;
   logic        verify_en = 1'b0;
   logic [15:0] rd_data = '0;
   logic [15:0] cin;
   logic [5:0]  caddr;
   logic [2:0]  cload;
   logic        valid_in, busy, done, err;

   fir_coef_ctrl_if hif ();

   fir_coef_ctrl #(.NUM_COF(N), .AW(6)) dut (
      .clk2(clk2), .rstn(rstn), .start(start),
      .verify_en(verify_en), .host(hif.slave),
      .rd_data(rd_data), .cin(cin), .caddr(caddr),
      .cload(cload), .valid_in(valid_in), .busy(busy),
      .done(done), .err(err)
   );

   always #5 clk2 = ~clk2;

   int checks = 0;
   int errors = 0;

   logic [15:0] words [N];
   logic [15:0] mem [N];
   logic [5:0]  wl_addr [$];
   logic [15:0] wl_data [$];
   logic [5:0]  rl_addr [$];
   int          strobe_bad = 0;
   bit          corrupt_en = 0;
   bit          rd_pend = 0;
   logic [15:0] rd_nxt = '0;
   logic [2:0]  p_cload = 3'b110;
   logic [5:0]  p_caddr = '0;
   logic [15:0] p_cin = '0;

   // core model: write/read memory plus strobe-protocol watchdog
   always @(negedge clk2) begin
      if (!rstn) begin
         p_cload = 3'b110;
         rd_pend = 0;
      end else begin
         if (cload == 3'b000) begin
            if (p_cload != 3'b010 || p_caddr != caddr || p_cin != cin)
               strobe_bad++;
            mem[caddr] = cin;
            wl_addr.push_back(caddr);
            wl_data.push_back(cin);
         end
         if (cload == 3'b001) begin
            if (p_cload != 3'b011 || p_caddr != caddr) strobe_bad++;
            rl_addr.push_back(caddr);
         end
         if (!p_cload[1] && !cload[1]) strobe_bad++;
         rd_pend = (cload == 3'b001);
         rd_nxt  = (corrupt_en && caddr == 6'd17) ? 16'hFFFF : mem[caddr];
         p_cload = cload;
         p_caddr = caddr;
         p_cin   = cin;
      end
   end

   always @(posedge clk2) rd_data <= rd_pend ? rd_nxt : 16'($urandom);

   int lat, done_cnt;
   bit valid_seen, err_seen, done_at_rise, done_after;
   bit timed_out, stall_bad;

   function automatic bit exp_err(input bit corrupt);
      int ws, rs;
      ws = 0;
      rs = 0;
      for (int i = 0; i < N; i++) begin
         ws += words[i];
         rs += (corrupt && i == 17) ? 16'hFFFF : words[i];
      end
      return ws[15:0] != rs[15:0];
   endfunction

   task automatic fill_rand();
      for (int i = 0; i < N; i++) words[i] = 16'($urandom);
   endtask

   task automatic reset_dut();
      hif.coef_valid = 0;
      start = 0;
      corrupt_en = 0;
      @(negedge clk2);
      rstn = 0;
      @(negedge clk2);
      rstn = 1;
      @(negedge clk2);
   endtask

   // lat counts cycles from the start cycle to the first valid_in cycle
   task automatic session(input bit ver, input bit corrupt,
                          input int stall_at, input int stall_len,
                          input int rd_start_addr);
      int idx, cyc, scnt;
      bit pulsed;
      wl_addr.delete();
      wl_data.delete();
      rl_addr.delete();
      strobe_bad = 0;
      corrupt_en = corrupt;
      lat = 0; done_cnt = 0; valid_seen = 0; err_seen = 0;
      done_at_rise = 0; done_after = 1; timed_out = 0; stall_bad = 0;
      idx = 0; cyc = 0; scnt = 0; pulsed = 0;
      @(negedge clk2);
      start = 1;
      verify_en = ver;
      hif.coef_valid = 0;
      @(negedge clk2);
      start = 0;
      verify_en = ~ver;
      while (!valid_seen && !err_seen && cyc < 1000) begin
         start = 0;
         if (rd_start_addr >= 0 && !pulsed && cload == 3'b001 &&
             caddr == 6'(rd_start_addr)) begin
            start = 1;
            pulsed = 1;
         end
         if (idx == stall_at && scnt < stall_len) begin
            hif.coef_valid = 0;
            scnt++;
            if (scnt >= 5 && (caddr != 6'(stall_at) || cload != 3'b110 ||
                wl_addr.size() != stall_at)) stall_bad = 1;
         end else if (idx < N) begin
            hif.coef_valid = 1;
            hif.coef_in = words[idx];
            if (hif.coef_ready) idx++;
         end else begin
            hif.coef_valid = 0;
         end
         @(negedge clk2);
         cyc++;
         done_cnt += int'(done);
         if (valid_in) begin
            valid_seen = 1;
            lat = cyc + 1;
            done_at_rise = done;
         end
         if (err) err_seen = 1;
      end
      start = 0;
      hif.coef_valid = 0;
      timed_out = (cyc >= 1000);
      @(negedge clk2);
      done_after = done;
      done_cnt += int'(done);
   endtask

   task automatic test_reset();
      #1 rstn = 0;
      hif.coef_valid = 0;
      hif.coef_in = '0;
      repeat (2) @(negedge clk2);
      checks += 8;
      if (cload !== 3'b110) begin errors++; $display("FAIL rst_cload got %b exp 110", cload); end
      if (cin !== 16'h0) begin errors++; $display("FAIL rst_cin got %h exp 0", cin); end
      if (caddr !== 6'd0) begin errors++; $display("FAIL rst_caddr got %0d exp 0", caddr); end
      if (hif.coef_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", hif.coef_ready); end
      if (valid_in !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_in); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
      if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
      rstn = 1;
      @(negedge clk2);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < N; i++) words[i] = 16'(i + 1);
      session(0, 0, -1, 0, -1);
      checks += 9;
      if (timed_out) begin errors++; $display("FAIL b2b_timeout got 1 exp 0"); end
      if (wl_addr.size() != N) begin errors++; $display("FAIL b2b_nwr got %0d exp %0d", wl_addr.size(), N); end
      if (lat != 3 * N + 1) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, 3 * N + 1); end
      if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_cnt got %0d exp 1", done_cnt); end
      if (!done_at_rise || done_after) begin errors++; $display("FAIL b2b_done_align got %b%b exp 10", done_at_rise, done_after); end
      if (err_seen) begin errors++; $display("FAIL b2b_err got 1 exp 0"); end
      if (rl_addr.size() != 0) begin errors++; $display("FAIL b2b_nrd got %0d exp 0", rl_addr.size()); end
      if (strobe_bad != 0) begin errors++; $display("FAIL b2b_strobe got %0d exp 0", strobe_bad); end
      if (busy !== 1'b0 || valid_in !== 1'b1 || cload !== 3'b110) begin
         errors++; $display("FAIL b2b_run got busy=%b valid=%b cload=%b exp 0 1 110", busy, valid_in, cload);
      end
      for (int i = 0; i < wl_addr.size(); i++) begin
         checks++;
         if (wl_addr[i] !== 6'(i) || wl_data[i] !== words[i]) begin
            errors++; $display("FAIL b2b_wr[%0d] got %0d/%h exp %0d/%h", i, wl_addr[i], wl_data[i], i, words[i]);
         end
      end
   endtask

   task automatic test_verify_pass();
      fill_rand();
      session(1, 0, -1, 0, 5);
      checks += 7;
      if (timed_out) begin errors++; $display("FAIL vp_timeout got 1 exp 0"); end
      if (err_seen !== exp_err(0)) begin errors++; $display("FAIL vp_err got %b exp %b", err_seen, exp_err(0)); end
      if (lat != 2 * (3 * N + 1)) begin errors++; $display("FAIL vp_latency got %0d exp %0d", lat, 2 * (3 * N + 1)); end
      if (done_cnt != 1) begin errors++; $display("FAIL vp_done_cnt got %0d exp 1", done_cnt); end
      if (rl_addr.size() != N) begin errors++; $display("FAIL vp_nrd got %0d exp %0d", rl_addr.size(), N); end
      if (wl_addr.size() != N) begin errors++; $display("FAIL vp_nwr got %0d exp %0d", wl_addr.size(), N); end
      if (strobe_bad != 0) begin errors++; $display("FAIL vp_strobe got %0d exp 0", strobe_bad); end
      for (int i = 0; i < rl_addr.size(); i++) begin
         checks++;
         if (rl_addr[i] !== 6'(i)) begin errors++; $display("FAIL vp_rd[%0d] got %0d exp %0d", i, rl_addr[i], i); end
      end
      for (int i = 0; i < wl_addr.size(); i++) begin
         checks++;
         if (wl_data[i] !== words[i]) begin errors++; $display("FAIL vp_wr[%0d] got %h exp %h", i, wl_data[i], words[i]); end
      end
   endtask

   task automatic test_start_in_run();
      start = 1;
      @(negedge clk2);
      start = 0;
      checks += 4;
      if (valid_in !== 1'b0) begin errors++; $display("FAIL sir_valid got %b exp 0", valid_in); end
      if (caddr !== 6'd0) begin errors++; $display("FAIL sir_caddr got %0d exp 0", caddr); end
      if (busy !== 1'b1) begin errors++; $display("FAIL sir_busy got %b exp 1", busy); end
      if (hif.coef_ready !== 1'b1) begin errors++; $display("FAIL sir_ready got %b exp 1", hif.coef_ready); end
      reset_dut();
   endtask

   task automatic test_verify_fail();
      fill_rand();
      if (words[17] == 16'hFFFF) words[17] = 16'h1234;
      session(1, 1, -1, 0, -1);
      checks += 4;
      if (timed_out) begin errors++; $display("FAIL vf_timeout got 1 exp 0"); end
      if (err_seen !== exp_err(1)) begin errors++; $display("FAIL vf_err got %b exp %b", err_seen, exp_err(1)); end
      if (valid_seen) begin errors++; $display("FAIL vf_valid got 1 exp 0"); end
      if (rl_addr.size() != N) begin errors++; $display("FAIL vf_nrd got %0d exp %0d", rl_addr.size(), N); end
      repeat (5) @(negedge clk2);
      checks += 2;
      if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL vf_hold got err=%b busy=%b exp 1 0", err, busy); end
      if (valid_in !== 1'b0) begin errors++; $display("FAIL vf_hold_valid got %b exp 0", valid_in); end
      start = 1;
      @(negedge clk2);
      start = 0;
      checks += 2;
      if (err !== 1'b0) begin errors++; $display("FAIL vf_clear got %b exp 0", err); end
      if (busy !== 1'b1 || caddr !== 6'd0) begin errors++; $display("FAIL vf_restart got busy=%b caddr=%0d exp 1 0", busy, caddr); end
      reset_dut();
   endtask

   // two stall cycles overlap the previous word's setup/strobe
   task automatic test_stall();
      fill_rand();
      session(0, 0, 5, 20, -1);
      checks += 4;
      if (stall_bad) begin errors++; $display("FAIL stall_hold got 1 exp 0"); end
      if (lat != 3 * N + 1 + 20 - 2) begin errors++; $display("FAIL stall_latency got %0d exp %0d", lat, 3 * N + 1 + 18); end
      if (wl_addr.size() != N) begin errors++; $display("FAIL stall_nwr got %0d exp %0d", wl_addr.size(), N); end
      if (strobe_bad != 0) begin errors++; $display("FAIL stall_strobe got %0d exp 0", strobe_bad); end
      for (int i = 0; i < wl_addr.size(); i++) begin
         checks++;
         if (wl_addr[i] !== 6'(i) || wl_data[i] !== words[i]) begin
            errors++; $display("FAIL stall_wr[%0d] got %0d/%h exp %0d/%h", i, wl_addr[i], wl_data[i], i, words[i]);
         end
      end
      reset_dut();
   endtask

   task automatic test_reset_mid_write();
      int idx, cyc;
      fill_rand();
      idx = 0;
      cyc = 0;
      @(negedge clk2);
      start = 1;
      verify_en = 0;
      @(negedge clk2);
      start = 0;
      while (idx < 10 && cyc < 200) begin
         hif.coef_valid = 1;
         hif.coef_in = words[idx];
         if (hif.coef_ready) idx++;
         @(negedge clk2);
         cyc++;
      end
      hif.coef_valid = 0;
      checks++;
      if (idx != 10) begin errors++; $display("FAIL rmw_reach got %0d exp 10", idx); end
      rstn = 0;
      @(negedge clk2);
      checks += 4;
      if (cload !== 3'b110) begin errors++; $display("FAIL rmw_cload got %b exp 110", cload); end
      if (valid_in !== 1'b0) begin errors++; $display("FAIL rmw_valid got %b exp 0", valid_in); end
      if (caddr !== 6'd0) begin errors++; $display("FAIL rmw_caddr got %0d exp 0", caddr); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rmw_busy got %b exp 0", busy); end
      rstn = 1;
      fill_rand();
      session(0, 0, -1, 0, -1);
      checks += 3;
      if (wl_addr.size() != N || wl_addr[0] !== 6'd0) begin
         errors++; $display("FAIL rmw_restart got n=%0d", wl_addr.size());
      end
      if (lat != 3 * N + 1) begin errors++; $display("FAIL rmw_latency got %0d exp %0d", lat, 3 * N + 1); end
      if (done_cnt != 1) begin errors++; $display("FAIL rmw_done got %0d exp 1", done_cnt); end
      for (int i = 0; i < wl_addr.size(); i++) begin
         checks++;
         if (wl_addr[i] !== 6'(i) || wl_data[i] !== words[i]) begin
            errors++; $display("FAIL rmw_wr[%0d] got %0d/%h exp %0d/%h", i, wl_addr[i], wl_data[i], i, words[i]);
         end
      end
      reset_dut();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_verify_pass();
      test_start_in_run();
      test_verify_fail();
      test_stall();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fir_coef_ctrl.md
# fir_coef_ctrl

Coefficient-load and stream-enable sequencer for `FIR_core`. It runs on `clk2` and takes 16-bit coefficients from a host valid/ready stream. It writes them into the core's coefficient memory over `cin`/`caddr`/`cload`, optionally reads them back and checks a checksum, and then raises `valid_in` so the core starts filtering. It replaces hand-driven `cload` toggling with one deterministic controller.

## Interface
Parameters:
- `NUM_COF`, 64, number of taps / coefficient words
- `AW`, 6, coefficient address width; must satisfy 2^AW >= NUM_COF

Ports:
- `clk2`  in  1  fast coefficient/control clock
- `rstn`  in  1  asynchronous active-low reset
- `start`  in  1  single-cycle pulse that begins a load session; honoured in IDLE, RUN and ERR, ignored otherwise
- `verify_en`  in  1  sampled at `start`; 1 = run the readback pass
- `coef_in`  in  16  host coefficient word
- `coef_valid`  in  1  host word valid
- `coef_ready`  out  1  controller accepts a word when `coef_valid && coef_ready`
- `rd_data`  in  16  core coefficient readback, valid the cycle after the read strobe
- `cin`  out  16  coefficient write data to the core
- `caddr`  out  AW  coefficient address to the core
- `cload`  out  3  core control. Bit 2 = 1 means the port is locked (core owns the memory). Bit 1 is an active-low strobe. Bit 0 = 1 means read, 0 means write.
- `valid_in`  out  1  core data-enable
- `busy`  out  1  high in every state except IDLE, RUN and ERR
- `done`  out  1  one-cycle pulse on entry to RUN
- `err`  out  1  high in ERR

## Operation
States and transitions:
- IDLE → WR_WAIT on `start`.
- WR_WAIT: `coef_ready`=1. On handshake, go to WR_SETUP.
- WR_SETUP → WR_STB.
- WR_STB → WR_WAIT if the address is not the last one. On the last address, go to RD_SETUP if `verify_en` was latched, otherwise to RUN.
- RD_SETUP → RD_STB → RD_CAP.
- RD_CAP → RD_SETUP if the address is not the last one, otherwise to CHECK.
- CHECK → RUN if `wsum == rsum`, otherwise to ERR.
- RUN and ERR are held until the next `start`, which goes to WR_WAIT.

Core interface per state (`cload` values):
- Idle/locked (IDLE, RUN, ERR, WR_WAIT, CHECK): `cload`=3'b110.
- Write setup (WR_SETUP): 3'b010. Write strobe (WR_STB): 3'b000.
- Read setup (RD_SETUP) and read capture (RD_CAP): 3'b011. Read strobe (RD_STB): 3'b001.

Datapath rules:
- The accepted word is registered into `cin` on the handshake edge. `cin` and `caddr` stay stable through SETUP and STB.
- `caddr` resets to 0 at `start` and increments on leaving WR_STB and on leaving RD_CAP. It reloads to 0 on entering RD_SETUP from the write phase.
- The last address is `NUM_COF-1`. `caddr` never wraps past it.
- `wsum` and `rsum` are 16-bit modulo-2^16 sums of written and read words. Both clear at `start`.
- `rsum` accumulates `rd_data` in RD_CAP.
- `valid_in`=1 only in RUN. It is registered, so it goes high on the edge entering RUN.
- `start` in RUN or ERR drops `valid_in` on the same edge that enters WR_WAIT, and clears `err`.
- `start` while `busy` is ignored.
- `coef_valid` may stay low indefinitely; WR_WAIT stalls with all outputs unchanged.

## Timing
Reset values:
- On `rstn`=0, the block goes to IDLE immediately (asynchronous).
- `cload`=3'b110, `cin`=0, `caddr`=0, `coef_ready`=0, `valid_in`=0, `busy`=0, `done`=0, `err`=0.
- Sums and the latched `verify_en` are cleared.
- Reset mid-session abandons it. No partial `valid_in` is produced.

Latency and strobe rules:
- Write phase: 3 cycles per coefficient with `coef_valid` held high, so 192 cycles for 64 taps. The first handshake happens the cycle after `start`.
- Read phase: 3 cycles per coefficient (192), plus 1 CHECK cycle.
- `start` to `valid_in`: 193 cycles without verify, 386 with verify.
- Each strobe is exactly 1 cycle low on `cload[1]`, with address and data valid one full cycle before and during it.
- `cload[0]` changes only while `cload[1]`=1.
- `done` pulses in the same cycle `valid_in` first rises.

## Test plan
- Reset mid-write at the 10th coefficient → next cycle `cload`=3'b110, `valid_in`=0, `caddr`=0, `busy`=0; a subsequent `start` restarts at address 0.
- `verify_en`=0, words 0x0001..0x0040 streamed back-to-back → 64 strobes of 3'b000 at addresses 0..63 carrying the matching words; `valid_in` rises 193 cycles after `start`; `done` pulses once.
- `verify_en`=1, core model returns written data → 64 read strobes of 3'b001 at addresses 0..63; CHECK passes; `valid_in` rises 386 cycles after `start`; `err`=0.
- `verify_en`=1, core model corrupts address 17 (returns 0xFFFF) → ERR, `err`=1, `valid_in` stays 0; the next `start` clears `err`.
- Host drops `coef_valid` for 20 cycles at word 5 → `caddr` stays at 5, no strobe occurs, and the sequence then resumes unchanged.
- `start` pulsed during RD_STB → ignored; `start` pulsed in RUN → `valid_in` falls on that edge and `caddr` returns to 0.
